// File: rtl/gb_fmap_reader_if.sv
// Reader-side bundle: buffer read port (request + 1-cycle valid-tagged return)
// and the outgoing word stream toward the PE array.
`timescale 1ns/1ps
interface gb_fmap_reader_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 256
);
  logic [ADDR_W-1:0] gb_raddr;
  logic              gb_rd_en;
  logic              gb_pad_en;
  logic [DATA_W-1:0] gb_data;
  logic              gb_data_vld;
  // Stream: a word transfers on a cycle where data_vld && data_rdy; while
  // data_vld is high and data_rdy low, data and data_vld hold unchanged.
  logic [DATA_W-1:0] data;
  logic              data_vld;
  logic              data_rdy;

  modport master (
    output gb_raddr, gb_rd_en, gb_pad_en, data, data_vld,
    input  gb_data, gb_data_vld, data_rdy
  );
  modport slave (
    input  gb_raddr, gb_rd_en, gb_pad_en, data, data_vld,
    output gb_data, gb_data_vld, data_rdy
  );
endinterface

// File: rtl/gb_fmap_reader.sv
// Walks one padded feature-map tile in raster order, issuing buffer read/pad
// requests under a FIFO credit limit and streaming returned words out.
`timescale 1ns/1ps
module gb_fmap_reader #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [7:0]        i_row_num,
  input  logic [7:0]        i_col_num,
  input  logic [1:0]        i_pad,
  input  logic [ADDR_W-1:0] i_row_stride,
  output logic              o_busy,
  output logic              o_done,
  output logic [1:0]        o_dbg_state,
  gb_fmap_reader_if.master  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] stride_q, row_base_q;
  logic [7:0]        h_q, w_q;
  logic [1:0]        pad_q;
  logic [8:0]        r_q, c_q;
  logic              inflight_q;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       cnt_q;

  logic [8:0]    pad9, h9, w9, row_last, col_last;
  logic          row_inner, col_inner, next_row_inner, pad_px;
  logic [PW+1:0] used_w;
  logic          credit_ok, issue, push, pop, empty;

  always_comb begin
    pad9           = {7'd0, pad_q};
    h9             = {1'b0, h_q};
    w9             = {1'b0, w_q};
    row_last       = h9 + pad9 + pad9 - 9'd1;
    col_last       = w9 + pad9 + pad9 - 9'd1;
    row_inner      = (r_q >= pad9) && (r_q < h9 + pad9);
    col_inner      = (c_q >= pad9) && (c_q < w9 + pad9);
    next_row_inner = (r_q + 9'd1) < (h9 + pad9);
    pad_px         = !(row_inner && col_inner);
    // inflight covers the word whose buffer return has not reached cnt_q yet
    used_w         = {1'b0, cnt_q} + {{(PW+1){1'b0}}, inflight_q};
    credit_ok      = used_w < DEPTH_W;
    issue          = (state_q == S_RUN) && credit_ok;
  end

  // Requests are decoded straight from the traversal registers so a request
  // and its one-cycle-later return line up with the single inflight bit.
  assign bus.gb_rd_en  = issue && !pad_px;
  assign bus.gb_pad_en = issue && pad_px;
  assign bus.gb_raddr  = (issue && !pad_px) ? row_base_q + ADDR_W'(c_q - pad9)
                                            : '0;

  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = (state_q == S_DONE);
  assign o_dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      stride_q   <= '0;
      row_base_q <= '0;
      h_q        <= '0;
      w_q        <= '0;
      pad_q      <= '0;
      r_q        <= '0;
      c_q        <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            stride_q   <= i_row_stride;
            row_base_q <= i_base_addr;
            h_q        <= i_row_num;
            w_q        <= i_col_num;
            pad_q      <= i_pad;
            r_q        <= '0;
            c_q        <= '0;
            state_q    <= (i_row_num == 8'd0 || i_col_num == 8'd0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (c_q == col_last) begin
              c_q <= '0;
              if (r_q == row_last) begin
                state_q <= S_DRAIN;
              end else begin
                r_q <= r_q + 9'd1;
                // row_base tracks the address of interior column 0
                if (row_inner && next_row_inner) row_base_q <= row_base_q + stride_q;
              end
            end else begin
              c_q <= c_q + 9'd1;
            end
          end
        end
        S_DRAIN: begin
          if (empty && !inflight_q) state_q <= S_DONE;
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign empty        = (cnt_q == '0);
  assign push         = bus.gb_data_vld && (cnt_q != DEPTH_C);
  assign pop          = !empty && bus.data_rdy;
  assign bus.data_vld = !empty;
  assign bus.data     = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.gb_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule
